// File: rtl/edge_sram_arbiter_if.sv
// rtl/edge_sram_arbiter_if.sv - shared SRAM port request/grant bundle between requesters and arbiter
interface edge_sram_arbiter_if #(
    parameter int NUM_PE = 4
);
    localparam int BW = $clog2(NUM_PE);
    localparam int IW = $clog2(NUM_PE + 1);

    logic                 pkt_req;
    logic [BW-1:0]        pkt_bank;
    logic                 pkt_acc;
    logic [NUM_PE-1:0]    pe_req;
    logic [NUM_PE*BW-1:0] pe_bank;
    logic [NUM_PE-1:0]    pe_acc;
    logic                 pkt_grant;
    logic [NUM_PE-1:0]    pe_grant;
    logic [NUM_PE-1:0]    bank_busy;
    logic [IW-1:0]        owner;

    modport master (
        output pkt_req, pkt_bank, pkt_acc, pe_req, pe_bank, pe_acc,
        input  pkt_grant, pe_grant, bank_busy, owner
    );

    modport slave (
        input  pkt_req, pkt_bank, pkt_acc, pe_req, pe_bank, pe_acc,
        output pkt_grant, pe_grant, bank_busy, owner
    );
endinterface

// File: rtl/edge_sram_arbiter.sv
// rtl/edge_sram_arbiter.sv - round-robin SRAM port arbiter with burst lock, turnaround gap and bank busy timers (optional PKT_PRIORITY_EN)
module edge_sram_arbiter #(
    parameter int NUM_PE    = 4,
    parameter int BANK_LAT  = 2,
    parameter int BURST_MAX = 8
) (
    input logic                clk,
    input logic                reset,
    edge_sram_arbiter_if.slave bus
);
    localparam int N  = NUM_PE + 1;
    localparam int BW = $clog2(NUM_PE);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(BURST_MAX);
    localparam int TW = $clog2(BANK_LAT + 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [TW-1:0]     timer_q [NUM_PE];
    logic [TW-1:0]     timer_d [NUM_PE];
    logic [NUM_PE-1:0] bank_busy_q, bank_busy_d;

    logic [N-1:0]      req;
    logic [N-1:0]      acc;
    logic [N-1:0]      eligible;
    logic [BW-1:0]     bank [N];
    logic              found;
    logic [IW-1:0]     winner;
    logic [IW:0]       idx_c;
    logic              strobe;
    logic [BW-1:0]     strobe_bank;

    // Flatten requesters into index space 0..N-1 (0 = packet path) and mask busy banks
    always_comb begin
        req     = {bus.pe_req, bus.pkt_req};
        acc     = {bus.pe_acc, bus.pkt_acc};
        bank[0] = bus.pkt_bank;
        for (int i = 0; i < NUM_PE; i++) begin
            bank[i+1] = bus.pe_bank[i*BW +: BW];
        end
        for (int k = 0; k < N; k++) begin
            eligible[k] = req[k] && !bank_busy_q[bank[k]];
        end
    end

    // First eligible requester searching upward from rr_ptr, wrapping modulo N
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx_c  = '0;
        for (int i = 0; i < N; i++) begin
            idx_c = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (idx_c >= (IW+1)'(N)) begin
                idx_c = idx_c - (IW+1)'(N);
            end
            if (!found && eligible[idx_c[IW-1:0]]) begin
                found  = 1'b1;
                winner = idx_c[IW-1:0];
            end
        end
`ifdef PKT_PRIORITY_EN
        if (eligible[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

    // Ownership FSM: grant after one-cycle arbitration, hold for a bounded burst, then one idle gap
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    owner_d         = winner;
                    burst_cnt_d     = '0;
                    state_d         = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner_q] || burst_cnt_q == CW'(BURST_MAX - 1)) begin
                    grant_d  = '0;
                    owner_d  = '0;
                    state_d  = GAP;
                    rr_ptr_d = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
`ifdef PKT_PRIORITY_EN
                    // The packet path does not take a round-robin turn
                    if (owner_q == '0) begin
                        rr_ptr_d = rr_ptr_q;
                    end
`endif
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bank timers: owner strobe reloads its current bank, all others count down to zero
    always_comb begin
        strobe      = grant_q[owner_q] && acc[owner_q];
        strobe_bank = bank[owner_q];
        for (int b = 0; b < NUM_PE; b++) begin
            timer_d[b] = (timer_q[b] != '0) ? timer_q[b] - 1'b1 : '0;
        end
        if (strobe) begin
            timer_d[strobe_bank] = TW'(BANK_LAT);
        end
        for (int b = 0; b < NUM_PE; b++) begin
            bank_busy_d[b] = (timer_d[b] != '0);
        end
    end

    // State and registered outputs; reset aborts any burst with no gap
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            bank_busy_q <= '0;
            for (int b = 0; b < NUM_PE; b++) begin
                timer_q[b] <= '0;
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            bank_busy_q <= bank_busy_d;
            for (int b = 0; b < NUM_PE; b++) begin
                timer_q[b] <= timer_d[b];
            end
        end
    end

    assign bus.pkt_grant = grant_q[0];
    assign bus.pe_grant  = grant_q[N-1:1];
    assign bus.bank_busy = bank_busy_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_edge_sram_arbiter.sv
// tb/tb_edge_sram_arbiter.sv - directed self-checking bench for edge_sram_arbiter
module tb_edge_sram_arbiter;
    localparam int NUM_PE = 4;
    localparam int BW     = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    edge_sram_arbiter_if #(.NUM_PE(NUM_PE)) bus_if ();

    edge_sram_arbiter #(.NUM_PE(NUM_PE), .BANK_LAT(2), .BURST_MAX(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pe_bank(input int pe, input logic [BW-1:0] b);
        bus_if.pe_bank[pe*BW +: BW] = b;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus_if.pkt_req   = 1'b0;
        bus_if.pkt_bank  = '0;
        bus_if.pkt_acc   = 1'b0;
        bus_if.pe_req    = '0;
        bus_if.pe_bank   = '0;
        bus_if.pe_acc    = '0;
        step(2);
        reset = 1'b0;
    endtask

    function automatic logic [4:0] gv();
        return {bus_if.pe_grant, bus_if.pkt_grant};
    endfunction

    logic [19:0] pattern;
    logic [4:0]  exp_g;
    logic [2:0]  exp_o;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset state
        do_reset();
        check("rst_grant", 32'(gv()), 32'h0);
        check("rst_busy", 32'(bus_if.bank_busy), 32'h0);
        check("rst_owner", 32'(bus_if.owner), 32'h0);

        // 1: single PE, one-cycle latency, release, single gap
        bus_if.pe_req[2] = 1'b1;
        set_pe_bank(2, 2'd1);
        step(1);
        check("t1_grant", 32'(bus_if.pe_grant), 32'h4);
        check("t1_owner", 32'(bus_if.owner), 32'd3);
        step(2);
        check("t1_hold", 32'(bus_if.pe_grant), 32'h4);
        bus_if.pe_req[2] = 1'b0;
        step(1);
        check("t1_release", 32'(gv()), 32'h0);
        check("t1_rel_owner", 32'(bus_if.owner), 32'h0);
        bus_if.pe_req[2] = 1'b1;
        step(1);
        check("t1_gap", 32'(gv()), 32'h0);
        step(1);
        check("t1_regrant", 32'(bus_if.pe_grant), 32'h4);

        // 2: burst limit on the packet path alone
        do_reset();
        bus_if.pkt_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            pattern[k] = bus_if.pkt_grant;
            check("t2_pe_idle", 32'(bus_if.pe_grant), 32'h0);
        end
        check("t2_pattern", 32'(pattern), 32'h3FCFF);

        // 3: round robin over all five requesters
        do_reset();
        bus_if.pkt_req  = 1'b1;
        bus_if.pkt_bank = 2'd0;
        bus_if.pe_req   = 4'hF;
        for (int i = 0; i < NUM_PE; i++) set_pe_bank(i, BW'(i));
        for (int k = 1; k <= 60; k++) begin
            step(1);
            if (((k - 1) % 10) < 8) begin
                exp_g = 5'b1 << (((k - 1) / 10) % 5);
                exp_o = 3'(((k - 1) / 10) % 5);
            end else begin
                exp_g = '0;
                exp_o = '0;
            end
            check($sformatf("t3_grant_c%0d", k), 32'(gv()), 32'(exp_g));
            check($sformatf("t3_owner_c%0d", k), 32'(bus_if.owner), 32'(exp_o));
        end

        // 4: bank masking after strobe-with-release
        do_reset();
        bus_if.pe_req[0] = 1'b1;
        set_pe_bank(0, 2'd3);
        step(1);
        check("t4_pe0_grant", 32'(bus_if.pe_grant), 32'h1);
        bus_if.pe_acc[0] = 1'b1;
        bus_if.pe_req[0] = 1'b0;
        bus_if.pe_req[1] = 1'b1;
        set_pe_bank(1, 2'd3);
        step(1);
        bus_if.pe_acc[0] = 1'b0;
        check("t4_a_grant", 32'(gv()), 32'h0);
        check("t4_a_busy", 32'(bus_if.bank_busy), 32'h8);
        step(1);
        check("t4_b_grant", 32'(gv()), 32'h0);
        check("t4_b_busy", 32'(bus_if.bank_busy), 32'h8);
        step(1);
        check("t4_c_masked", 32'(gv()), 32'h0);
        check("t4_c_busy", 32'(bus_if.bank_busy), 32'h0);
        step(1);
        check("t4_d_grant", 32'(bus_if.pe_grant), 32'h2);
        check("t4_d_owner", 32'(bus_if.owner), 32'd2);
        set_pe_bank(2, 2'd2);
        bus_if.pe_acc[2] = 1'b1;
        step(1);
        bus_if.pe_acc[2] = 1'b0;
        check("t4_nonowner_acc", 32'(bus_if.bank_busy), 32'h0);
        bus_if.pe_acc[1] = 1'b1;
        step(1);
        bus_if.pe_acc[1] = 1'b0;
        check("t4_owner_acc", 32'(bus_if.bank_busy), 32'h8);
        check("t4_keep_grant", 32'(bus_if.pe_grant), 32'h2);

        // 5: req drop coinciding with burst limit
        do_reset();
        bus_if.pe_req[3] = 1'b1;
        set_pe_bank(3, 2'd2);
        step(8);
        check("t5_last_cycle", 32'(bus_if.pe_grant), 32'h8);
        bus_if.pe_req[3] = 1'b0;
        step(1);
        check("t5_release", 32'(gv()), 32'h0);
        bus_if.pkt_req   = 1'b1;
        bus_if.pe_req[0] = 1'b1;
        step(1);
        check("t5_gap", 32'(gv()), 32'h0);
        step(1);
        check("t5_rr_wrap", 32'(gv()), 32'h1);

        // 6: reset mid-burst with a busy bank
        do_reset();
        bus_if.pe_req[0] = 1'b1;
        step(1);
        check("t6_grant", 32'(bus_if.pe_grant), 32'h1);
        bus_if.pe_acc[0] = 1'b1;
        step(1);
        bus_if.pe_acc[0] = 1'b0;
        check("t6_busy", 32'(bus_if.bank_busy), 32'h1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t6_rst_grant", 32'(gv()), 32'h0);
        check("t6_rst_busy", 32'(bus_if.bank_busy), 32'h0);
        check("t6_rst_owner", 32'(bus_if.owner), 32'h0);
        step(1);
        check("t6_no_gap", 32'(bus_if.pe_grant), 32'h1);

        // Packet path vs PE contention with rr_ptr past index 0
        do_reset();
        bus_if.pe_req[0] = 1'b1;
        step(1);
        bus_if.pe_req[0] = 1'b0;
        step(1);
        bus_if.pkt_req   = 1'b1;
        bus_if.pe_req[1] = 1'b1;
        set_pe_bank(1, 2'd1);
        step(1);
        check("prio_gap", 32'(gv()), 32'h0);
        step(1);
`ifdef PKT_PRIORITY_EN
        check("prio_pkt_wins", 32'(gv()), 32'h1);
`else
        check("rr_pe1_wins", 32'(gv()), 32'h4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
